// File: rtl/axil_stream_fifo_bridge.sv
// axil_stream_fifo_bridge
// AXI4-Lite register front end over two word FIFOs. The CPU pushes TX words that drain
// on the axi_str_txd master, and pops words that the axi_str_rxd slave has buffered.
// Build option: define AXIS_FIFO_STORE_FWD_EN to hold txd_tvalid until a whole packet
// (closed by a TDFL write) is buffered. Without it the bridge runs cut-through.
module axil_stream_fifo_bridge #(
  parameter int TX_DEPTH_LOG2 = 9,
  parameter int RX_DEPTH_LOG2 = 9,
  parameter int ADDR_LSB_W    = 6
) (
  input  logic        clk,
  input  logic        s_axi_aresetn,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        interrupt,
  output logic        mm2s_prmry_reset_out_n,
  output logic        s2mm_prmry_reset_out_n,
  output logic        axi_str_txd_tvalid,
  input  logic        axi_str_txd_tready,
  output logic        axi_str_txd_tlast,
  output logic [31:0] axi_str_txd_tdata,
  input  logic        axi_str_rxd_tvalid,
  output logic        axi_str_rxd_tready,
  input  logic        axi_str_rxd_tlast,
  input  logic [31:0] axi_str_rxd_tdata
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;

  localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE  = TX_DEPTH_LOG2'(1);
  localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE  = RX_DEPTH_LOG2'(1);
  localparam logic [TX_DEPTH_LOG2:0]   TX_CNT_ONE  = (TX_DEPTH_LOG2+1)'(1);
  localparam logic [RX_DEPTH_LOG2:0]   RX_CNT_ONE  = (RX_DEPTH_LOG2+1)'(1);
  localparam logic [TX_DEPTH_LOG2:0]   TX_CNT_FULL = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
  localparam logic [RX_DEPTH_LOG2:0]   RX_CNT_FULL = {1'b1, {RX_DEPTH_LOG2{1'b0}}};

  localparam logic [ADDR_LSB_W-1:0] A_ISR  = ADDR_LSB_W'(32'h00);
  localparam logic [ADDR_LSB_W-1:0] A_IER  = ADDR_LSB_W'(32'h04);
  localparam logic [ADDR_LSB_W-1:0] A_TDFV = ADDR_LSB_W'(32'h08);
  localparam logic [ADDR_LSB_W-1:0] A_TDFD = ADDR_LSB_W'(32'h0C);
  localparam logic [ADDR_LSB_W-1:0] A_TDFL = ADDR_LSB_W'(32'h10);
  localparam logic [ADDR_LSB_W-1:0] A_RDFO = ADDR_LSB_W'(32'h14);
  localparam logic [ADDR_LSB_W-1:0] A_RDFD = ADDR_LSB_W'(32'h18);
  localparam logic [ADDR_LSB_W-1:0] A_RSR  = ADDR_LSB_W'(32'h1C);
  localparam logic [ADDR_LSB_W-1:0] A_SRR  = ADDR_LSB_W'(32'h20);

  localparam logic [31:0] SRR_KEY = 32'h0000_00A5;
  localparam logic [1:0]  RESP_OK = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Storage: bit 32 carries the tlast flag alongside the data word.
  logic [32:0] tx_mem [TX_DEPTH];
  logic [32:0] rx_mem [RX_DEPTH];

  logic [TX_DEPTH_LOG2-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TX_DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;
  logic [RX_DEPTH_LOG2-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RX_DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
  logic [15:0]              rx_pkts_q, rx_pkts_d;

  logic [3:0]  isr_q, isr_d, ier_q, isr_set, isr_clr;
  logic        irq_q, rst_out_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic        rvalid_q;
  logic [31:0] rdata_q, rd_mux;

  logic [ADDR_LSB_W-1:0] wa, ra;
  logic wr_hs, rd_hs, srr_hit;
  logic tx_full, tx_empty, tx_push_req, tx_push, tx_pop, tx_ovf;
  logic rx_full, rx_empty, rx_push, rx_pop_req, rx_pop, rx_unf;
  logic [32:0] tx_head, rx_head;

  // Upper address bits and byte strobes have no effect on this register file.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr[31:ADDR_LSB_W], s_axi_araddr[31:ADDR_LSB_W], s_axi_wstrb};

  assign wa = s_axi_awaddr[ADDR_LSB_W-1:0];
  assign ra = s_axi_araddr[ADDR_LSB_W-1:0];

  // One write and one read in flight; ready only when the response slot is free.
  assign wr_hs = s_axi_aresetn & s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
  assign rd_hs = s_axi_aresetn & s_axi_arvalid & ~rvalid_q;
  assign s_axi_awready = wr_hs;
  assign s_axi_wready  = wr_hs;
  assign s_axi_arready = rd_hs;

  assign srr_hit = wr_hs && (wa == A_SRR) && (s_axi_wdata == SRR_KEY);

  assign tx_full     = (tx_cnt_q == TX_CNT_FULL);
  assign tx_empty    = (tx_cnt_q == '0);
  assign tx_push_req = wr_hs && ((wa == A_TDFD) || (wa == A_TDFL));
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_ovf      = tx_push_req & tx_full;
  assign tx_head     = tx_mem[tx_rp_q];

`ifdef AXIS_FIFO_STORE_FWD_EN
  logic [TX_DEPTH_LOG2:0] tx_pkts_q, tx_pkts_d;
  logic                   tx_pkt_in, tx_pkt_out;

  assign tx_pkt_in  = tx_push & (wa == A_TDFL);
  assign tx_pkt_out = tx_pop & tx_head[32];
  assign axi_str_txd_tvalid = (tx_pkts_q != '0);

  // Complete-packet count gating the stream; in and out together leave it unchanged.
  always_comb begin
    tx_pkts_d = tx_pkts_q;
    if (tx_pkt_in && !tx_pkt_out)      tx_pkts_d = tx_pkts_q + TX_CNT_ONE;
    else if (tx_pkt_out && !tx_pkt_in) tx_pkts_d = tx_pkts_q - TX_CNT_ONE;
  end

  // Packet count register, cleared by reset and by the soft reset key.
  always_ff @(posedge clk) begin
    if (!s_axi_aresetn || srr_hit) tx_pkts_q <= '0;
    else                           tx_pkts_q <= tx_pkts_d;
  end
`else
  assign axi_str_txd_tvalid = ~tx_empty;
`endif

  assign tx_pop            = axi_str_txd_tvalid & axi_str_txd_tready;
  assign axi_str_txd_tdata = tx_head[31:0];
  assign axi_str_txd_tlast = tx_head[32];

  assign rx_full    = (rx_cnt_q == RX_CNT_FULL);
  assign rx_empty   = (rx_cnt_q == '0);
  assign axi_str_rxd_tready = s_axi_aresetn & ~rx_full;
  assign rx_push    = axi_str_rxd_tvalid & axi_str_rxd_tready;
  assign rx_pop_req = rd_hs && (ra == A_RDFD);
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign rx_unf     = rx_pop_req & rx_empty;
  assign rx_head    = rx_mem[rx_rp_q];

  assign tx_wp_d = tx_push ? tx_wp_q + TX_PTR_ONE : tx_wp_q;
  assign tx_rp_d = tx_pop  ? tx_rp_q + TX_PTR_ONE : tx_rp_q;
  assign rx_wp_d = rx_push ? rx_wp_q + RX_PTR_ONE : rx_wp_q;
  assign rx_rp_d = rx_pop  ? rx_rp_q + RX_PTR_ONE : rx_rp_q;

  // Occupancy and RX packet count next-state; push and pop together cancel out.
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TX_CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - TX_CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RX_CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - RX_CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase
    rx_pkts_d = rx_pkts_q;
    if ((rx_push && axi_str_rxd_tlast) && !(rx_pop && rx_head[32])) begin
      if (rx_pkts_q != 16'hFFFF) rx_pkts_d = rx_pkts_q + 16'd1;
    end else if ((rx_pop && rx_head[32]) && !(rx_push && axi_str_rxd_tlast)) begin
      if (rx_pkts_q != 16'd0) rx_pkts_d = rx_pkts_q - 16'd1;
    end
  end

  // FIFO storage writes; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= {(wa == A_TDFL), s_axi_wdata};
    if (rx_push) rx_mem[rx_wp_q] <= {axi_str_rxd_tlast, axi_str_rxd_tdata};
  end

  // FIFO pointers and counts; the soft reset key discards everything including a partial packet.
  always_ff @(posedge clk) begin
    if (!s_axi_aresetn || srr_hit) begin
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      rx_pkts_q <= '0;
    end else begin
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_pkts_q <= rx_pkts_d;
    end
  end

  assign isr_set = {rx_unf, tx_ovf, rx_push & axi_str_rxd_tlast, tx_pop & tx_head[32]};
  assign isr_clr = (wr_hs && (wa == A_ISR)) ? s_axi_wdata[3:0] : 4'd0;
  assign isr_d   = (isr_q & ~isr_clr) | isr_set;

  // Interrupt status/enable and the downstream reset pulse; ISR/IER survive a soft reset.
  always_ff @(posedge clk) begin
    if (!s_axi_aresetn) begin
      isr_q     <= '0;
      ier_q     <= '0;
      irq_q     <= 1'b0;
      rst_out_q <= 1'b0;
    end else begin
      isr_q     <= isr_d;
      if (wr_hs && (wa == A_IER)) ier_q <= s_axi_wdata[3:0];
      irq_q     <= |(isr_q & ier_q);
      rst_out_q <= ~srr_hit;
    end
  end

  assign interrupt              = irq_q;
  assign mm2s_prmry_reset_out_n = rst_out_q;
  assign s2mm_prmry_reset_out_n = rst_out_q;

  // Write response channel.
  always_ff @(posedge clk) begin
    if (!s_axi_aresetn) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OK;
    end else if (wr_hs) begin
      bvalid_q <= 1'b1;
      bresp_q  <= tx_ovf ? RESP_SLVERR : RESP_OK;
    end else if (s_axi_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // Read data selection at address handshake time.
  always_comb begin
    rd_mux = '0;
    case (ra)
      A_ISR:   rd_mux = {28'd0, isr_q};
      A_IER:   rd_mux = {28'd0, ier_q};
      A_TDFV:  rd_mux = 32'(TX_CNT_FULL - tx_cnt_q);
      A_RDFO:  rd_mux = 32'(rx_cnt_q);
      A_RDFD:  rd_mux = rx_empty ? 32'd0 : rx_head[31:0];
      A_RSR:   rd_mux = {rx_pkts_q, 15'd0, ~rx_empty & rx_head[32]};
      default: rd_mux = '0;
    endcase
  end

  // Read data channel.
  always_ff @(posedge clk) begin
    if (!s_axi_aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OK;
    end else if (rd_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
      rresp_q  <= rx_unf ? RESP_SLVERR : RESP_OK;
    end else if (s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;

endmodule

// File: tb/tb_axil_stream_fifo_bridge.sv
// Bench for axil_stream_fifo_bridge built with 4-deep FIFOs so full/empty edges are quick
// to reach. Expected bus responses, TX beats and RX words are queued as stimulus is driven
// and popped when the DUT produces them.
module tb_axil_stream_fifo_bridge;

  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef AXIS_FIFO_STORE_FWD_EN
  localparam logic SF = 1'b1;
`else
  localparam logic SF = 1'b0;
`endif

  localparam logic [31:0] A_ISR = 32'h00, A_IER = 32'h04, A_TDFV = 32'h08, A_TDFD = 32'h0C;
  localparam logic [31:0] A_TDFL = 32'h10, A_RDFO = 32'h14, A_RDFD = 32'h18, A_RSR = 32'h1C;
  localparam logic [31:0] A_SRR = 32'h20;

  logic        clk = 1'b0;
  logic        s_axi_aresetn;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic        interrupt, mm2s_prmry_reset_out_n, s2mm_prmry_reset_out_n;
  logic        axi_str_txd_tvalid, axi_str_txd_tready, axi_str_txd_tlast;
  logic [31:0] axi_str_txd_tdata;
  logic        axi_str_rxd_tvalid, axi_str_rxd_tready, axi_str_rxd_tlast;
  logic [31:0] axi_str_rxd_tdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0]  b_exp_q[$];
  logic [33:0] r_exp_q[$];
  logic [32:0] tx_exp[$];
  logic [32:0] rx_model[$];
  logic        rx_done;

  always #5 clk = ~clk;

  axil_stream_fifo_bridge #(
    .TX_DEPTH_LOG2(DEPTH_LOG2),
    .RX_DEPTH_LOG2(DEPTH_LOG2),
    .ADDR_LSB_W(6)
  ) dut (
    .clk(clk), .s_axi_aresetn(s_axi_aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .interrupt(interrupt),
    .mm2s_prmry_reset_out_n(mm2s_prmry_reset_out_n),
    .s2mm_prmry_reset_out_n(s2mm_prmry_reset_out_n),
    .axi_str_txd_tvalid(axi_str_txd_tvalid), .axi_str_txd_tready(axi_str_txd_tready),
    .axi_str_txd_tlast(axi_str_txd_tlast), .axi_str_txd_tdata(axi_str_txd_tdata),
    .axi_str_rxd_tvalid(axi_str_rxd_tvalid), .axi_str_rxd_tready(axi_str_rxd_tready),
    .axi_str_rxd_tlast(axi_str_rxd_tlast), .axi_str_rxd_tdata(axi_str_rxd_tdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // TX beats leaving the DUT are compared against words pushed earlier.
  always @(posedge clk) begin
    logic [63:0] e;
    if (s_axi_aresetn && axi_str_txd_tvalid && axi_str_txd_tready) begin
      e = (tx_exp.size() != 0) ? 64'(tx_exp.pop_front()) : 64'hFFFF_FFFF_FFFF_FFFF;
      check("tx_beat", {31'd0, axi_str_txd_tlast, axi_str_txd_tdata}, e);
    end
  end

  // RX words the DUT accepts become the expected pop data.
  always @(posedge clk) begin
    if (s_axi_aresetn && axi_str_rxd_tvalid && axi_str_rxd_tready)
      rx_model.push_back({axi_str_rxd_tlast, axi_str_rxd_tdata});
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] exp_resp, input string tag);
    int n;
    b_exp_q.push_back(exp_resp);
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    #1;
    n = 0;
    while (!s_axi_awready && n < 20) begin @(negedge clk); #1; n++; end
    check({tag, "_awready"}, 64'(s_axi_awready & s_axi_wready), 64'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
    check({tag, "_bvalid"}, 64'(s_axi_bvalid), 64'd1);
    check({tag, "_bresp"}, 64'(s_axi_bresp), 64'(b_exp_q.pop_front()));
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
    int n;
    r_exp_q.push_back({exp_resp, exp_data});
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    #1;
    n = 0;
    while (!s_axi_arready && n < 20) begin @(negedge clk); #1; n++; end
    check({tag, "_arready"}, 64'(s_axi_arready), 64'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
    check({tag, "_rvalid"}, 64'(s_axi_rvalid), 64'd1);
    check({tag, "_rdata"}, 64'({s_axi_rresp, s_axi_rdata}), 64'(r_exp_q.pop_front()));
  endtask

  task automatic pop_rx(input string tag);
    logic [32:0] w;
    if (rx_model.size() == 0) axi_read(A_RDFD, 32'd0, 2'b10, tag);
    else begin
      w = rx_model.pop_front();
      axi_read(A_RDFD, w[31:0], 2'b00, tag);
    end
  endtask

  function automatic logic [31:0] rsr_exp();
    int c = 0;
    foreach (rx_model[i]) if (rx_model[i][32]) c++;
    return {16'(c), 15'd0, (rx_model.size() != 0) ? rx_model[0][32] : 1'b0};
  endfunction

  task automatic rx_send(input logic [31:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    axi_str_rxd_tvalid = 1'b1; axi_str_rxd_tdata = d; axi_str_rxd_tlast = l;
    @(posedge clk);
    while (!axi_str_rxd_tready && n < 200) begin @(posedge clk); n++; end
    check("rx_send_accept", 64'(axi_str_rxd_tready), 64'd1);
    #1 axi_str_rxd_tvalid = 1'b0;
  endtask

  task automatic tx_push(input logic [31:0] addr, input logic [31:0] d, input string tag);
    tx_exp.push_back({addr == A_TDFL, d});
    axi_write(addr, d, 2'b00, tag);
  endtask

  initial begin
    int n;
    s_axi_aresetn = 1'b0;
    s_axi_awaddr = '0; s_axi_wdata = 32'h5A5A_5A5A; s_axi_wstrb = 4'hF; s_axi_araddr = '0;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    axi_str_txd_tready = 1'b1;
    axi_str_rxd_tvalid = 1'b1; axi_str_rxd_tlast = 1'b1; axi_str_rxd_tdata = 32'hDEAD_BEEF;
    rx_done = 1'b0;

    // Reset with every request asserted: nothing may respond.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_handshakes", 64'({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
          s_axi_rvalid, axi_str_txd_tvalid, axi_str_rxd_tready}), 64'd0);
    check("reset_outs", 64'({interrupt, mm2s_prmry_reset_out_n, s2mm_prmry_reset_out_n,
          s_axi_bresp, s_axi_rresp, s_axi_rdata}), 64'd0);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    axi_str_rxd_tvalid = 1'b0; axi_str_txd_tready = 1'b0;
    s_axi_aresetn = 1'b1;
    @(negedge clk);
    check("reset_out_n_release", 64'({mm2s_prmry_reset_out_n, s2mm_prmry_reset_out_n}), 64'd3);
    axi_read(A_TDFV, DEPTH, 2'b00, "reset_tdfv");
    axi_read(A_RDFO, 32'd0, 2'b00, "reset_rdfo");
    axi_read(A_ISR, 32'd0, 2'b00, "reset_isr");

    // TX packet of three words.
    tx_push(A_TDFD, 32'h11, "tx_w0");
    repeat (2) @(negedge clk);
    check("tx_tvalid_before_tdfl", 64'(axi_str_txd_tvalid), 64'(!SF));
    tx_push(A_TDFD, 32'h22, "tx_w1");
    tx_push(A_TDFL, 32'h33, "tx_w2");
    @(negedge clk); axi_str_txd_tready = 1'b1;
    n = 0;
    while (tx_exp.size() != 0 && n < 20) begin @(negedge clk); n++; end
    check("tx_drained", 64'(tx_exp.size()), 64'd0);
    axi_str_txd_tready = 1'b0;
    axi_read(A_ISR, 32'h1, 2'b00, "tx_isr");
    axi_write(A_ISR, 32'h1, 2'b00, "tx_isr_w1c");
    axi_read(A_ISR, 32'h0, 2'b00, "tx_isr_clr");

    // RX packet of three words with rx_pkt_rcvd enabled.
    axi_write(A_IER, 32'h2, 2'b00, "rx_ier");
    rx_send(32'hA1, 1'b0);
    rx_send(32'hA2, 1'b0);
    rx_send(32'hA3, 1'b1);
    repeat (3) @(negedge clk);
    check("rx_irq", 64'(interrupt), 64'd1);
    axi_read(A_RDFO, 32'(rx_model.size()), 2'b00, "rx_rdfo");
    axi_read(A_RSR, rsr_exp(), 2'b00, "rx_rsr0");
    pop_rx("rx_pop0");
    pop_rx("rx_pop1");
    axi_read(A_RSR, rsr_exp(), 2'b00, "rx_rsr_headlast");
    pop_rx("rx_pop2");
    axi_read(A_RSR, rsr_exp(), 2'b00, "rx_rsr_empty");
    axi_write(A_ISR, 32'h2, 2'b00, "rx_isr_w1c");
    repeat (2) @(negedge clk);
    check("rx_irq_clr", 64'(interrupt), 64'd0);
    axi_write(A_IER, 32'h0, 2'b00, "rx_ier_off");

    // TX overflow and RX underflow.
    for (int i = 0; i < DEPTH; i++) tx_push(A_TDFD, 32'hB0 + i, "ovf_push");
    axi_write(A_TDFD, 32'hBF, 2'b10, "ovf_5th");
    check("ovf_tvalid", 64'(axi_str_txd_tvalid), 64'(!SF));
    axi_read(A_TDFV, 32'd0, 2'b00, "ovf_tdfv");
    axi_read(A_ISR, 32'h4, 2'b00, "ovf_isr");
    pop_rx("unf_pop");
    axi_read(A_ISR, 32'hC, 2'b00, "unf_isr");
    axi_write(A_ISR, 32'hC, 2'b00, "unf_w1c");
    axi_read(A_ISR, 32'h0, 2'b00, "unf_isr_clr");
    axi_write(32'h24, 32'hFFFF_FFFF, 2'b00, "unmapped_wr");
    axi_read(32'h3C, 32'd0, 2'b00, "unmapped_rd");

    // Soft reset: wrong key ignored, right key flushes mid packet.
    axi_write(A_IER, 32'h5, 2'b00, "srr_ier");
    axi_write(A_SRR, 32'h5A, 2'b00, "srr_badkey");
    axi_read(A_TDFV, 32'd0, 2'b00, "srr_badkey_tdfv");
    axi_write(A_SRR, 32'hA5, 2'b00, "srr_key");
    tx_exp.delete();
    check("srr_tvalid", 64'(axi_str_txd_tvalid), 64'd0);
    check("srr_rst_out_low", 64'({mm2s_prmry_reset_out_n, s2mm_prmry_reset_out_n}), 64'd0);
    @(negedge clk);
    check("srr_rst_out_high", 64'({mm2s_prmry_reset_out_n, s2mm_prmry_reset_out_n}), 64'd3);
    axi_read(A_TDFV, DEPTH, 2'b00, "srr_tdfv");
    axi_read(A_IER, 32'h5, 2'b00, "srr_ier_kept");
    axi_write(A_IER, 32'h0, 2'b00, "srr_ier_off");

    // RX backpressure: six beats into a four-word FIFO.
    fork
      begin
        for (int i = 0; i < 6; i++) rx_send(32'hC0 + i, i == 5);
        rx_done = 1'b1;
      end
    join_none
    repeat (12) @(negedge clk);
    check("rxfull_tready", 64'(axi_str_rxd_tready), 64'd0);
    axi_read(A_RDFO, 32'(rx_model.size()), 2'b00, "rxfull_rdfo");
    check("rxfull_model_size", 64'(rx_model.size()), 64'(DEPTH));
    pop_rx("rxfull_pop0");
    check("rxfull_tready_after_pop", 64'(axi_str_rxd_tready), 64'd1);
    pop_rx("rxfull_pop1");
    n = 0;
    while (!rx_done && n < 100) begin @(negedge clk); n++; end
    check("rxfull_sender_done", 64'(rx_done), 64'd1);
    for (int i = 0; i < 4; i++) pop_rx("rxfull_drain");
    axi_read(A_RSR, rsr_exp(), 2'b00, "rxfull_rsr");
    axi_read(A_RDFO, 32'd0, 2'b00, "rxfull_rdfo_end");
    check("irq_masked", 64'(interrupt), 64'd0);
    check("rx_model_empty", 64'(rx_model.size()), 64'd0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
